// File: rtl/onchip_mem_s2_arbiter.sv
// rtl/onchip_mem_s2_arbiter.sv - two-requester arbiter onto a single-port on-chip memory
// Tie-break: fixed priority (rq0 wins) by default; round-robin when ARB_ROUND_ROBIN_EN is defined.
module onchip_mem_s2_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,

  input  logic                  rq0_valid,
  input  logic                  rq0_write,
  input  logic [ADDR_W-1:0]     rq0_addr,
  input  logic [DATA_W-1:0]     rq0_wdata,
  input  logic [DATA_W/8-1:0]   rq0_byteen,
  output logic                  rq0_ready,
  output logic                  rq0_rvalid,
  output logic [DATA_W-1:0]     rq0_rdata,

  input  logic                  rq1_valid,
  input  logic                  rq1_write,
  input  logic [ADDR_W-1:0]     rq1_addr,
  input  logic [DATA_W-1:0]     rq1_wdata,
  input  logic [DATA_W/8-1:0]   rq1_byteen,
  output logic                  rq1_ready,
  output logic                  rq1_rvalid,
  output logic [DATA_W-1:0]     rq1_rdata,

  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_clken,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic                    gnt0;
  logic                    gnt1;
  logic                    accept;
  logic                    sel;
  logic                    cmd_write;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [DATA_W-1:0]       cmd_wdata;
  logic [BE_W-1:0]         cmd_byteen;
  logic                    issue_id;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;
`endif

  // mem_clken doubles as the "out of reset" flag, so no grant is issued while reset is sampled.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (mem_clken) begin
      if (rq0_valid && rq1_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = rq0_valid;
        gnt1 = rq1_valid;
      end
    end
  end

  assign rq0_ready  = gnt0;
  assign rq1_ready  = gnt1;
  assign accept     = gnt0 | gnt1;
  assign sel        = gnt1;
  assign cmd_write  = sel ? rq1_write  : rq0_write;
  assign cmd_addr   = sel ? rq1_addr   : rq0_addr;
  assign cmd_wdata  = sel ? rq1_wdata  : rq0_wdata;
  assign cmd_byteen = sel ? rq1_byteen : rq0_byteen;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      mem_clken      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      issue_id       <= 1'b0;
      tag_valid      <= '0;
      tag_id         <= '0;
      rq0_rvalid     <= 1'b0;
      rq1_rvalid     <= 1'b0;
      rq0_rdata      <= '0;
      rq1_rdata      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt       <= 1'b1;
`endif
    end else begin
      mem_clken      <= 1'b1;
      mem_chipselect <= accept;
      mem_write      <= accept & cmd_write;
      if (accept) begin
        mem_address    <= cmd_addr;
        mem_writedata  <= cmd_wdata;
        mem_byteenable <= cmd_write ? cmd_byteen : {BE_W{1'b1}};
        issue_id       <= sel;
`ifdef ARB_ROUND_ROBIN_EN
        last_gnt       <= sel;
`endif
      end

      // Tag stage i describes the read whose chipselect was i+1 cycles ago.
      tag_valid[0] <= mem_chipselect & ~mem_write;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end

      rq0_rvalid <= tag_valid[READ_LATENCY-1] & ~tag_id[READ_LATENCY-1];
      rq1_rvalid <= tag_valid[READ_LATENCY-1] &  tag_id[READ_LATENCY-1];
      if (tag_valid[READ_LATENCY-1]) begin
        if (tag_id[READ_LATENCY-1]) rq1_rdata <= mem_readdata;
        else                        rq0_rdata <= mem_readdata;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_s2_arbiter.sv
// tb/tb_onchip_mem_s2_arbiter.sv - directed self-checking bench for onchip_mem_s2_arbiter
module tb_onchip_mem_s2_arbiter;

  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset_reset_n;
  logic        rq0_valid, rq0_write, rq1_valid, rq1_write;
  logic [14:0] rq0_addr, rq1_addr;
  logic [31:0] rq0_wdata, rq1_wdata;
  logic [3:0]  rq0_byteen, rq1_byteen;
  logic        rq0_ready, rq0_rvalid, rq1_ready, rq1_rvalid;
  logic [31:0] rq0_rdata, rq1_rdata;
  logic [14:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_model [0:255];
  logic [31:0] rd_pipe   [0:RL-1];

  always #5 clk = ~clk;

  onchip_mem_s2_arbiter #(.ADDR_W(15), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .rq0_valid(rq0_valid), .rq0_write(rq0_write), .rq0_addr(rq0_addr),
    .rq0_wdata(rq0_wdata), .rq0_byteen(rq0_byteen), .rq0_ready(rq0_ready),
    .rq0_rvalid(rq0_rvalid), .rq0_rdata(rq0_rdata),
    .rq1_valid(rq1_valid), .rq1_write(rq1_write), .rq1_addr(rq1_addr),
    .rq1_wdata(rq1_wdata), .rq1_byteen(rq1_byteen), .rq1_ready(rq1_ready),
    .rq1_rvalid(rq1_rvalid), .rq1_rdata(rq1_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  // Memory model: readdata valid RL cycles after the chipselect cycle.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_model[mem_address[7:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        rd_pipe[0] <= mem_model[mem_address[7:0]];
      end
    end
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[RL-1];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clear;
    rq0_valid = 1'b0;
    rq1_valid = 1'b0;
  endtask

  task automatic drive(input int k, input logic w, input logic [14:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (k == 0) begin
      rq0_valid = 1'b1; rq0_write = w; rq0_addr = a; rq0_wdata = d; rq0_byteen = be;
    end else begin
      rq1_valid = 1'b1; rq1_write = w; rq1_addr = a; rq1_wdata = d; rq1_byteen = be;
    end
  endtask

  task automatic test_reset;
    reset_reset_n = 1'b0;
    drive(0, 1'b0, 15'h5, 32'h0, 4'h0);
    repeat (3) tick;
    #1;
    checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL reset_clken got=%b exp=0", mem_clken); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", mem_chipselect); end
    checks++; if (rq0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", rq0_ready); end
    checks++; if (rq0_rvalid !== 1'b0 || rq1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%b%b exp=00", rq0_rvalid, rq1_rvalid); end
    checks++; if (rq0_rdata !== 32'h0 || rq1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0", rq0_rdata, rq1_rdata); end
    checks++; if (mem_address !== 15'h0 || mem_writedata !== 32'h0) begin errors++; $display("FAIL reset_addr_data got=%h/%h exp=0", mem_address, mem_writedata); end
    clear;
    reset_reset_n = 1'b1;
    tick;
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL release_clken got=%b exp=1", mem_clken); end
  endtask

  task automatic test_write;
    drive(0, 1'b1, 15'h0010, 32'hDEADBEEF, 4'hF);
    #1;
    checks++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin errors++; $display("FAIL wr_ready got=%b%b exp=10", rq0_ready, rq1_ready); end
    tick;
    clear;
    checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_strobe got=%b%b exp=11", mem_chipselect, mem_write); end
    checks++; if (mem_address !== 15'h0010 || mem_writedata !== 32'hDEADBEEF || mem_byteenable !== 4'hF) begin
      errors++; $display("FAIL wr_cmd got=%h/%h/%h exp=0010/deadbeef/f", mem_address, mem_writedata, mem_byteenable); end
    tick;
    checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_address !== 15'h0010) begin
      errors++; $display("FAIL wr_idle got=%b%b/%h exp=00/0010", mem_chipselect, mem_write, mem_address); end
    for (int c = 0; c < RL + 2; c++) begin
      checks++; if (rq0_rvalid !== 1'b0 || rq1_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid c=%0d got=%b%b exp=00", c, rq0_rvalid, rq1_rvalid); end
      tick;
    end
  endtask

  task automatic test_read;
    drive(1, 1'b0, 15'h0010, 32'h0, 4'h0);
    #1;
    checks++; if (rq1_ready !== 1'b1 || rq0_ready !== 1'b0) begin errors++; $display("FAIL rd_ready got=%b%b exp=01", rq0_ready, rq1_ready); end
    tick;
    clear;
    for (int c = 1; c <= RL + 3; c++) begin
      if (c == 1) begin
        checks++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_address !== 15'h0010) begin
          errors++; $display("FAIL rd_cmd got=%b%b/%h/%h exp=10/f/0010", mem_chipselect, mem_write, mem_byteenable, mem_address); end
      end
      checks++; if (rq1_rvalid !== (c == RL + 2) || rq0_rvalid !== 1'b0) begin
        errors++; $display("FAIL rd_rvalid c=%0d got=%b%b exp=0%b", c, rq0_rvalid, rq1_rvalid, (c == RL + 2)); end
      if (c >= RL + 2) begin
        checks++; if (rq1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data c=%0d got=%h exp=deadbeef", c, rq1_rdata); end
      end
      tick;
    end
  endtask

  task automatic test_byteen;
    drive(1, 1'b1, 15'h0010, 32'hAAAA5555, 4'h3);
    tick; clear;
    checks++; if (mem_byteenable !== 4'h3 || mem_write !== 1'b1) begin errors++; $display("FAIL be_partial got=%h/%b exp=3/1", mem_byteenable, mem_write); end
    drive(0, 1'b1, 15'h0010, 32'h12345678, 4'h0);
    tick; clear;
    checks++; if (mem_byteenable !== 4'h0 || mem_chipselect !== 1'b1) begin errors++; $display("FAIL be_zero got=%h/%b exp=0/1", mem_byteenable, mem_chipselect); end
    drive(0, 1'b0, 15'h0010, 32'h0, 4'h0);
    tick; clear;
    repeat (RL + 1) tick;
    checks++; if (rq0_rvalid !== 1'b1 || rq0_rdata !== 32'hDEAD5555) begin
      errors++; $display("FAIL be_readback got=%b/%h exp=1/dead5555", rq0_rvalid, rq0_rdata); end
    tick;
  endtask

  task automatic test_tie;
    logic e0;
    drive(0, 1'b1, 15'h0020, 32'h0, 4'h0);
    drive(1, 1'b1, 15'h0021, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e0 = (i % 2 == 0);
`else
      e0 = 1'b1;
`endif
      #1;
      checks++; if (rq0_ready !== e0 || rq1_ready !== !e0) begin
        errors++; $display("FAIL tie_grant i=%0d got=%b%b exp=%b%b", i, rq0_ready, rq1_ready, e0, !e0); end
      tick;
      checks++; if (mem_chipselect !== 1'b1 || mem_address !== (e0 ? 15'h0020 : 15'h0021)) begin
        errors++; $display("FAIL tie_addr i=%0d got=%b/%h exp=1/%h", i, mem_chipselect, mem_address, (e0 ? 15'h0020 : 15'h0021)); end
    end
    clear;
    tick;
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL tie_idle got=%b exp=0", mem_chipselect); end
  endtask

  task automatic test_drop;
    drive(0, 1'b1, 15'h0030, 32'h0, 4'h0);
    drive(1, 1'b1, 15'h0031, 32'h0, 4'h0);
    #1;
    checks++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin errors++; $display("FAIL drop_grant got=%b%b exp=10", rq0_ready, rq1_ready); end
    tick; clear;
    checks++; if (mem_chipselect !== 1'b1 || mem_address !== 15'h0030) begin errors++; $display("FAIL drop_first got=%b/%h exp=1/0030", mem_chipselect, mem_address); end
    tick;
    checks++; if (mem_chipselect !== 1'b0 || mem_address !== 15'h0030) begin errors++; $display("FAIL drop_none got=%b/%h exp=0/0030", mem_chipselect, mem_address); end
  endtask

  task automatic test_back_to_back;
    logic e0, e1, er;
    drive(0, 1'b1, 15'h1, 32'h11110001, 4'hF); tick;
    drive(0, 1'b1, 15'h2, 32'h22220002, 4'hF); tick;
    drive(0, 1'b1, 15'h3, 32'h33330003, 4'hF); tick;
    clear; tick;
    for (int c = 0; c <= RL + 6; c++) begin
      clear;
      if (c == 0) drive(0, 1'b0, 15'h1, 32'h0, 4'h0);
      if (c == 1) drive(1, 1'b0, 15'h2, 32'h0, 4'h0);
      if (c == 2) drive(0, 1'b0, 15'h3, 32'h0, 4'h0);
      #1;
      if (c < 3) begin
        er = (c != 1);
        checks++; if (rq0_ready !== er || rq1_ready !== !er) begin
          errors++; $display("FAIL b2b_ready c=%0d got=%b%b exp=%b%b", c, rq0_ready, rq1_ready, er, !er); end
      end
      e0 = (c == RL + 2) || (c == RL + 4);
      e1 = (c == RL + 3);
      checks++; if (rq0_rvalid !== e0 || rq1_rvalid !== e1) begin
        errors++; $display("FAIL b2b_rvalid c=%0d got=%b%b exp=%b%b", c, rq0_rvalid, rq1_rvalid, e0, e1); end
      if (e0) begin
        checks++; if (rq0_rdata !== ((c == RL + 2) ? 32'h11110001 : 32'h33330003)) begin
          errors++; $display("FAIL b2b_rdata0 c=%0d got=%h", c, rq0_rdata); end
      end
      if (e1) begin
        checks++; if (rq1_rdata !== 32'h22220002) begin errors++; $display("FAIL b2b_rdata1 c=%0d got=%h exp=22220002", c, rq1_rdata); end
      end
      tick;
    end
    clear;
  endtask

  task automatic test_reset_inflight;
    drive(0, 1'b0, 15'h1, 32'h0, 4'h0);
    tick; clear;
    reset_reset_n = 1'b0;
    tick; tick;
    reset_reset_n = 1'b1;
    tick;
    for (int c = 0; c < RL + 4; c++) begin
      checks++; if (rq0_rvalid !== 1'b0 || rq1_rvalid !== 1'b0 || rq0_rdata !== 32'h0) begin
        errors++; $display("FAIL inflight c=%0d got=%b%b/%h exp=00/0", c, rq0_rvalid, rq1_rvalid, rq0_rdata); end
      tick;
    end
    drive(0, 1'b1, 15'h0040, 32'h0, 4'h0);
    drive(1, 1'b1, 15'h0041, 32'h0, 4'h0);
    #1;
    checks++; if (rq0_ready !== 1'b1 || rq1_ready !== 1'b0) begin errors++; $display("FAIL post_reset_tie got=%b%b exp=10", rq0_ready, rq1_ready); end
    tick; clear;
    checks++; if (mem_address !== 15'h0040) begin errors++; $display("FAIL post_reset_addr got=%h exp=0040", mem_address); end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    rq0_valid = 1'b0; rq0_write = 1'b0; rq0_addr = '0; rq0_wdata = '0; rq0_byteen = '0;
    rq1_valid = 1'b0; rq1_write = 1'b0; rq1_addr = '0; rq1_wdata = '0; rq1_byteen = '0;
    tick;
    test_reset;
    test_write;
    test_read;
    test_byteen;
    test_tie;
    test_drop;
    test_back_to_back;
    test_reset_inflight;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
